hilo_mult_unit: RTL and testbench
=================================

HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port: start  input  1  launch MULTU; driven by decoder HI_en & LO_en.
REQ-004 SHALL provide port: abort  input  1  synchronous cancel of an in-flight multiply.
REQ-005 SHALL provide port: a  input  32  multiplicand (rs value), unsigned.
REQ-006 SHALL provide port: b  input  32  multiplier (rt value), unsigned.
REQ-007 SHALL provide port: hilo_sel  input  1  read select; 0 = HI (MFHI), 1 = LO (MFLO).
REQ-008 SHALL provide port: hilo_out  output  32  selected HI/LO register contents.
REQ-009 SHALL provide port: hi  output  32  HI register, upper product half.
REQ-010 SHALL provide port: lo  output  32  LO register, lower product half.
REQ-011 SHALL provide port: busy  output  1  multiply in progress; core stalls while high.
REQ-012 SHALL provide port: done  output  1  one-cycle pulse; HI/LO just updated.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE); both Moore outputs.
REQ-014 IDLE: start=1 and abort=0 sampled at edge E0 -> latch a into 32-bit multiplicand, load {32'b0, b} into 64-bit product register, clear 5-bit iteration counter, go to RUN.
REQ-015 RUN: each edge performs one shift-add step: 33-bit sum = P[63:32] + (P[0] ? multiplicand : 0); P <= {sum, P[31:1]}; counter increments.
REQ-016 Carry out of the 32-bit add SHALL be retained in the shift (33-bit sum), never dropped.
REQ-017 On the 32nd RUN edge (E32, counter==31) HI <= final P[63:32], LO <= final P[31:0], state -> DONE.
REQ-018 Latency: busy high for exactly 32 cycles (E0..E32); done high for exactly one cycle (E32..E33); state returns to IDLE at E33.
REQ-019 HI/LO SHALL change only at E32 of a completed multiply or on reset; reads during RUN return the previous result.
REQ-020 hilo_out SHALL be combinational: hilo_sel ? LO : HI, with zero-cycle read latency.
REQ-021 start in RUN or DONE SHALL be ignored (no queueing); operands are not resampled.
REQ-022 abort=1 in RUN SHALL return to IDLE at the next edge, HI/LO unchanged, no done pulse.
REQ-023 abort and start both high in IDLE: abort wins; no multiply launched.
REQ-024 abort in DONE SHALL have no effect; the result is already committed.
REQ-025 Product SHALL be exact unsigned 64-bit a*b for all 32-bit operands, including 0 and 0xFFFFFFFF.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, busy=0, done=0, HI=0, LO=0, product register=0, counter=0, multiplicand=0, independent of clk.
REQ-027 rst asserted mid-RUN SHALL abort the operation; no partial result reaches HI/LO.
REQ-028 After rst deasserts, start is accepted at the first rising edge.

Verification
REQ-029 Reset: rst=1 at RUN cycle 10 -> busy=0, hi=0, lo=0, hilo_out=0 with no clock edge needed.
REQ-030 Basic: a=3, b=5, start one cycle -> busy high 32 cycles, single done pulse, hi=0x00000000, lo=0x0000000F; hilo_sel=1 -> hilo_out=0xF.
REQ-031 Max: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (carry path).
REQ-032 Carry boundary: a=0x80000000, b=2 -> hi=0x00000001, lo=0x00000000; hilo_sel=0 -> hilo_out=1.
REQ-033 Ignored start: a=7, b=6 launched; at RUN cycle 5 start=1 with a=9, b=9 -> result hi=0, lo=42; exactly one done pulse.
REQ-034 Abort: prior result lo=42; new multiply aborted at RUN cycle 10 -> busy low next edge, no done, hi=0, lo=42 retained; start+abort together in IDLE -> busy stays 0.

Source files
------------

// File: rtl/hilo_mult_unit.sv
// ============================================================================
// Module   : hilo_mult_unit
// Brief    : 32x32 unsigned shift-add multiplier feeding HI/LO registers (MULTU).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_mult_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_sel,
    output logic [31:0] hilo_out,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_load;
    logic        w_step;
    logic        w_commit;

    logic [31:0] r_mcand;
    logic [63:0] r_prod;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [32:0] w_sum;
    logic [63:0] w_prod_next;

    // 33-bit sum keeps the carry so it shifts into the product instead of being lost.
    assign w_sum       = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_prod_next = {w_sum, r_prod[31:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == c_LAST_STEP) begin
                        w_commit     = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= 32'd0;
            r_prod  <= 64'd0;
            r_cnt   <= 5'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            if (w_load) begin
                r_mcand <= a;
                r_prod  <= {32'd0, b};
                r_cnt   <= 5'd0;
            end else if (w_step) begin
                r_prod <= w_prod_next;
                r_cnt  <= r_cnt + 5'd1;
            end
            // HI/LO take the final step's value directly, so an aborted run never touches them.
            if (w_commit) begin
                r_hi <= w_prod_next[63:32];
                r_lo <= w_prod_next[31:0];
            end
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign hilo_out = hilo_sel ? r_lo : r_hi;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_hilo_mult_unit.sv
// ============================================================================
// Module   : tb_hilo_mult_unit
// Brief    : Directed and random checks of hilo_mult_unit against a 64-bit multiply model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_mult_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_sel;
    logic [31:0] hilo_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_pass;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    hilo_mult_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .a        (a),
        .b        (b),
        .hilo_sel (hilo_sel),
        .hilo_out (hilo_out),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // abort_at / restart_at are RUN-cycle indices (0 = first cycle busy is high); -1 disables.
    task automatic run_mult(input logic [31:0] ta, input logic [31:0] tbv, input int abort_at,
                            input int restart_at, input bit abort_done, input string tag);
        logic [63:0] exp_prod;
        int          n_busy;
        bit          hold_ok;
        bit          early_done;
        exp_prod   = {32'd0, ta} * {32'd0, tbv};
        a          = ta;
        b          = tbv;
        start      = 1'b1;
        abort      = 1'b0;
        tick();
        start      = 1'b0;
        n_busy     = 0;
        hold_ok    = 1'b1;
        early_done = 1'b0;
        while (busy && n_busy < 40) begin
            if (hi !== mdl_hi || lo !== mdl_lo) hold_ok = 1'b0;
            if (done) early_done = 1'b1;
            if (n_busy == restart_at) begin
                start = 1'b1;
                a     = 32'd9;
                b     = 32'd9;
            end else begin
                start = 1'b0;
            end
            abort  = (n_busy == abort_at);
            n_busy++;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        check({tag, " busy_cycles"}, 64'(n_busy), (abort_at >= 0) ? 64'(abort_at + 1) : 64'd32);
        check({tag, " hilo_hold"}, {63'd0, hold_ok}, 64'd1);
        check({tag, " no_early_done"}, {63'd0, early_done}, 64'd0);
        if (abort_at >= 0) begin
            check({tag, " abort_no_done"}, {63'd0, done}, 64'd0);
            check({tag, " abort_hi"}, {32'd0, hi}, {32'd0, mdl_hi});
            check({tag, " abort_lo"}, {32'd0, lo}, {32'd0, mdl_lo});
        end else begin
            mdl_hi = exp_prod[63:32];
            mdl_lo = exp_prod[31:0];
            check({tag, " done"}, {63'd0, done}, 64'd1);
            check({tag, " hi"}, {32'd0, hi}, {32'd0, mdl_hi});
            check({tag, " lo"}, {32'd0, lo}, {32'd0, mdl_lo});
            hilo_sel = 1'b0;
            #1;
            check({tag, " hilo_out_hi"}, {32'd0, hilo_out}, {32'd0, mdl_hi});
            hilo_sel = 1'b1;
            #1;
            check({tag, " hilo_out_lo"}, {32'd0, hilo_out}, {32'd0, mdl_lo});
            abort = abort_done;
            tick();
            abort = 1'b0;
            check({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
            check({tag, " idle_after"}, {63'd0, busy}, 64'd0);
            check({tag, " hi_kept"}, {32'd0, hi}, {32'd0, mdl_hi});
            check({tag, " lo_kept"}, {32'd0, lo}, {32'd0, mdl_lo});
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mdl_hi   = 32'd0;
        mdl_lo   = 32'd0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        hilo_sel = 1'b0;
        #12;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_mult(32'd3, 32'd5, -1, -1, 1'b0, "basic");
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0, "max");
        run_mult(32'h8000_0000, 32'd2, -1, -1, 1'b0, "carry");
        run_mult(32'd0, 32'hDEAD_BEEF, -1, -1, 1'b0, "zero_a");
        run_mult(32'd7, 32'd6, -1, 5, 1'b0, "ignored_start");
        run_mult(32'd123, 32'd456, 10, -1, 1'b0, "abort_run");

        // start and abort together in IDLE must not launch anything
        a     = 32'd11;
        b     = 32'd13;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort busy", {63'd0, busy}, 64'd0);
        tick();
        check("start_abort still_idle", {63'd0, busy}, 64'd0);
        check("start_abort lo", {32'd0, lo}, {32'd0, mdl_lo});

        run_mult(32'h1234_5678, 32'h9ABC_DEF0, -1, -1, 1'b1, "abort_in_done");

        for (int i = 0; i < 6; i++) begin
            run_mult($urandom, $urandom, -1, -1, 1'b0, $sformatf("rand%0d", i));
        end

        // asynchronous reset in the middle of RUN, checked before the next edge
        a     = 32'hCAFE_F00D;
        b     = 32'h0BAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        mdl_hi   = 32'd0;
        mdl_lo   = 32'd0;
        hilo_sel = 1'b0;
        #0;
        check("midrun_rst busy", {63'd0, busy}, 64'd0);
        check("midrun_rst done", {63'd0, done}, 64'd0);
        check("midrun_rst hi", {32'd0, hi}, 64'd0);
        check("midrun_rst lo", {32'd0, lo}, 64'd0);
        check("midrun_rst hilo_out", {32'd0, hilo_out}, 64'd0);
        #1;
        rst = 1'b0;
        run_mult(32'd100, 32'd200, -1, -1, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
